// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer: walks a per-profile register table in a synchronous ROM,
// issuing SCCB writes with retry, local delays, end markers and deferred abort.
module ov7670_cfg_sequencer #(
  parameter int NUM_PROFILES = 4,
  parameter int TABLE_DEPTH = 256,
  parameter int DELAY_UNIT_CYCLES = 27000,
  parameter int RETRY_MAX = 3,
  parameter logic [7:0] DELAY_REG = 8'hFF,
  parameter logic [15:0] END_MARKER = 16'hFFFF,
  localparam int PROF_W = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int IDX_W = $clog2(TABLE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic [PROF_W-1:0]       profile_i,
  input  logic                    abort_i,
  output logic [PROF_W+IDX_W-1:0] rom_addr_o,
  input  logic [15:0]             rom_data_i,
  output logic                    sccb_valid_o,
  input  logic                    sccb_ready_i,
  output logic [7:0]              sccb_reg_o,
  output logic [7:0]              sccb_data_o,
  input  logic                    sccb_done_i,
  input  logic                    sccb_err_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [IDX_W:0]          write_count_o
);
  localparam int CNT_W = $clog2(255 * DELAY_UNIT_CYCLES + 1);
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_WRITE = 3'd3,
                         S_WAIT_ACK = 3'd4, S_DELAY = 3'd5, S_DONE = 3'd6, S_ERROR = 3'd7;
  logic [2:0]        state_q, state_d, adv_state;
  logic [PROF_W-1:0] profile_q, profile_d;
  logic [IDX_W-1:0]  index_q, index_d, adv_idx;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        reg_q, reg_d, data_q, data_d;
  logic [IDX_W:0]    wcnt_q, wcnt_d;
  logic              error_q, error_d, abort_q, abort_d, ab;
  assign rom_addr_o    = {profile_q, index_q};
  assign sccb_valid_o  = (state_q == S_WRITE) && !abort_i;
  assign sccb_reg_o    = reg_q;
  assign sccb_data_o   = data_q;
  assign busy_o        = state_q != S_IDLE;
  assign done_o        = state_q == S_DONE;
  assign error_o       = error_q;
  assign write_count_o = wcnt_q;
  assign ab            = abort_i | abort_q;
  always_comb begin
    state_d   = state_q;
    profile_d = profile_q;
    index_d   = index_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    reg_d     = reg_q;
    data_d    = data_q;
    wcnt_d    = wcnt_q;
    error_d   = error_q;
    abort_d   = 1'b0;
    adv_state = (index_q == IDX_W'(TABLE_DEPTH - 1)) ? S_DONE : S_FETCH;
    adv_idx   = (index_q == IDX_W'(TABLE_DEPTH - 1)) ? index_q : index_q + 1'b1;
    case (state_q)
      S_IDLE:
        if (start_i && !abort_i) begin
          profile_d = profile_i;
          index_d   = '0;
          retry_d   = '0;
          wcnt_d    = '0;
          error_d   = 1'b0;
          state_d   = S_FETCH;
        end
      S_FETCH: state_d = abort_i ? S_IDLE : S_DECODE;
      S_DECODE:
        if (abort_i) state_d = S_IDLE;
        else if (rom_data_i == END_MARKER) state_d = S_DONE;
        else if (rom_data_i[15:8] == DELAY_REG && rom_data_i[7:0] != 8'd0) begin
          cnt_d   = CNT_W'(rom_data_i[7:0]) * CNT_W'(DELAY_UNIT_CYCLES) - 1'b1;
          state_d = S_DELAY;
        end else if (rom_data_i[15:8] == DELAY_REG) begin
          state_d = adv_state;
          index_d = adv_idx;
        end else begin
          reg_d   = rom_data_i[15:8];
          data_d  = rom_data_i[7:0];
          state_d = S_WRITE;
        end
      S_WRITE: state_d = abort_i ? S_IDLE : sccb_ready_i ? S_WAIT_ACK : S_WRITE;
      S_WAIT_ACK: begin
        // abort is remembered here and honoured only once the transaction completes
        abort_d = ab;
        if (sccb_done_i) begin
          abort_d = 1'b0;
          if (!sccb_err_i) begin
            wcnt_d  = wcnt_q + 1'b1;
            retry_d = '0;
            state_d = ab ? S_IDLE : adv_state;
            index_d = ab ? index_q : adv_idx;
          end else if (ab) state_d = S_IDLE;
          else if (retry_q < RTY_W'(RETRY_MAX)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_DELAY:
        if (abort_i) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = adv_state;
          index_d = adv_idx;
        end else cnt_d = cnt_q - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_IDLE;
      profile_q <= '0;
      index_q   <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      wcnt_q    <= '0;
      error_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      profile_q <= profile_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      error_q   <= error_d;
      abort_q   <= abort_d;
    end
endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// tb_ov7670_cfg_sequencer: scoreboard bench with a ROM model and an SCCB responder
// that can delay completions and inject errors.
module tb_ov7670_cfg_sequencer;
  logic        clk = 0, reset_n = 0;
  logic        start_i = 0, abort_i = 0, sccb_ready_i = 1, sccb_done_i = 0, sccb_err_i = 0;
  logic [1:0]  profile_i = 0;
  logic [3:0]  rom_addr_o;
  logic [15:0] rom_data_i = 0;
  logic        sccb_valid_o, busy_o, done_o, error_o;
  logic [7:0]  sccb_reg_o, sccb_data_o;
  logic [2:0]  write_count_o;
  logic [15:0] rom [16];
  logic [15:0] exp_q [$];
  int          hs_log [$];
  int          cyc = 0, done_n = 0, att_n = 0, err_until = 0, done_lat = 1;
  int          pass_n = 0, total_n = 0;

  ov7670_cfg_sequencer #(.NUM_PROFILES(4), .TABLE_DEPTH(4), .DELAY_UNIT_CYCLES(10),
    .RETRY_MAX(3), .DELAY_REG(8'hFF), .END_MARKER(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .profile_i(profile_i), .abort_i(abort_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .sccb_valid_o(sccb_valid_o),
    .sccb_ready_i(sccb_ready_i), .sccb_reg_o(sccb_reg_o), .sccb_data_o(sccb_data_o),
    .sccb_done_i(sccb_done_i), .sccb_err_i(sccb_err_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .write_count_o(write_count_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // SCCB responder: completion done_lat cycles after a handshake, error while att_n < err_until
  initial begin
    logic hs, perr;
    int pend;
    pend = 0; perr = 0;
    forever begin
      @(negedge clk);
      hs = reset_n && sccb_valid_o && sccb_ready_i;
      @(posedge clk); #1;
      sccb_done_i = 0; sccb_err_i = 0;
      if (hs) begin pend = done_lat; perr = att_n < err_until; att_n++; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin sccb_done_i = 1; sccb_err_i = perr; end
      end
    end
  end

  // monitor: every handshake is compared against the scoreboard
  initial forever begin
    @(negedge clk);
    if (reset_n && sccb_valid_o && sccb_ready_i) begin
      hs_log.push_back(cyc);
      check("sccb_expected_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sccb_write", {sccb_reg_o, sccb_data_o}, exp_q.pop_front());
    end
    if (done_o) done_n++;
  end

  task automatic start(input logic [1:0] p, output int s);
    @(posedge clk); #1;
    start_i = 1; profile_i = p; s = cyc;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy_o && n < lim) begin @(posedge clk); #1; n++; end
    check("idle_timeout", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, h0, d0, a0;
    rom = '{16'h1280, 16'hFF03, 16'h0400, 16'hFFFF,
            16'h1280, 16'h1101, 16'hFFFF, 16'h0000,
            16'h1280, 16'hFF00, 16'h0400, 16'hFFFF,
            16'h0111, 16'h0222, 16'h0333, 16'h0444};
    repeat (3) @(posedge clk); #1;
    check("rst_rom_addr", rom_addr_o, 0);
    check("rst_sccb", {sccb_valid_o, sccb_reg_o, sccb_data_o}, 0);
    check("rst_flags", {busy_o, done_o, error_o}, 0);
    check("rst_wcnt", write_count_o, 0);
    reset_n = 1;

    // profile 1: two plain writes then end marker
    h0 = hs_log.size(); d0 = done_n;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    start(2'd1, s);
    wait_idle(200);
    check("p1_hs_count", hs_log.size() - h0, 2);
    if (hs_log.size() >= h0 + 2) begin
      check("p1_start_latency", hs_log[h0] - s, 3);
      check("p1_b2b_gap", hs_log[h0+1] - hs_log[h0], 4);
    end
    check("p1_done", done_n - d0, 1);
    check("p1_wcnt", write_count_o, 2);
    check("p1_error", error_o, 0);
    check("p1_profile_addr", rom_addr_o[3:2], 1);

    // profile 0: 3-unit delay between writes (1 ack + 2 fetch/decode + 30 delay + 3)
    h0 = hs_log.size(); d0 = done_n;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h0400);
    start(2'd0, s);
    wait_idle(300);
    check("p0_hs_count", hs_log.size() - h0, 2);
    if (hs_log.size() >= h0 + 2) check("p0_delay_gap", hs_log[h0+1] - hs_log[h0], 36);
    check("p0_done", done_n - d0, 1);

    // profile 2: zero delay entry costs only its fetch/decode
    h0 = hs_log.size();
    exp_q.push_back(16'h1280); exp_q.push_back(16'h0400);
    start(2'd2, s);
    wait_idle(200);
    if (hs_log.size() >= h0 + 2) check("p2_zero_delay_gap", hs_log[h0+1] - hs_log[h0], 6);
    else check("p2_hs_count", hs_log.size() - h0, 2);

    // two errors then success on the first entry
    d0 = done_n; a0 = att_n; err_until = att_n + 2;
    repeat (3) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
    start(2'd1, s);
    wait_idle(300);
    check("retry_attempts", att_n - a0, 4);
    check("retry_done", done_n - d0, 1);
    check("retry_wcnt", write_count_o, 2);
    check("retry_error", error_o, 0);

    // every attempt fails
    d0 = done_n; a0 = att_n; err_until = att_n + 100;
    repeat (4) exp_q.push_back(16'h1280);
    start(2'd1, s);
    wait_idle(300);
    check("fail_attempts", att_n - a0, 4);
    check("fail_error", error_o, 1);
    check("fail_busy", busy_o, 0);
    check("fail_done", done_n - d0, 0);
    check("fail_wcnt", write_count_o, 0);
    err_until = att_n;

    // profile 3: no end marker, start while busy ignored, error cleared on start
    h0 = hs_log.size(); d0 = done_n;
    exp_q.push_back(16'h0111); exp_q.push_back(16'h0222);
    exp_q.push_back(16'h0333); exp_q.push_back(16'h0444);
    start(2'd3, s);
    check("p3_error_cleared", error_o, 0);
    repeat (4) @(posedge clk); #1;
    start_i = 1; profile_i = 2'd0;
    @(posedge clk); #1;
    start_i = 0;
    @(posedge clk); #1;
    check("p3_profile_kept", rom_addr_o[3:2], 3);
    wait_idle(300);
    check("p3_hs_count", hs_log.size() - h0, 4);
    check("p3_done", done_n - d0, 1);
    check("p3_wcnt", write_count_o, 4);

    // abort during DELAY
    d0 = done_n;
    exp_q.push_back(16'h1280);
    start(2'd0, s);
    repeat (14) @(posedge clk); #1;
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    check("abort_delay_idle", busy_o, 0);
    repeat (5) @(posedge clk); #1;
    check("abort_delay_done", done_n - d0, 0);
    check("abort_delay_error", error_o, 0);
    check("abort_delay_wcnt", write_count_o, 1);

    // abort during WAIT_ACK: held off until the slow completion arrives
    d0 = done_n; done_lat = 6;
    exp_q.push_back(16'h1280);
    start(2'd1, s);
    repeat (4) @(posedge clk); #1;
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    check("abort_ack_busy", busy_o, 1);
    check("abort_ack_valid", sccb_valid_o, 0);
    repeat (2) @(posedge clk); #1;
    check("abort_ack_still_busy", busy_o, 1);
    repeat (2) @(posedge clk); #1;
    check("abort_ack_idle", busy_o, 0);
    repeat (4) @(posedge clk); #1;
    check("abort_ack_done", done_n - d0, 0);
    check("abort_ack_wcnt", write_count_o, 1);
    check("abort_ack_error", error_o, 0);
    done_lat = 1;

    // reset asserted mid-WRITE
    sccb_ready_i = 0;
    start(2'd1, s);
    repeat (2) @(posedge clk); #1;
    check("midwrite_valid", {sccb_valid_o, sccb_reg_o}, 9'h112);
    #2 reset_n = 0;
    #1;
    check("midwrite_rst_sccb", {sccb_valid_o, sccb_reg_o, sccb_data_o}, 0);
    check("midwrite_rst_addr", rom_addr_o, 0);
    check("midwrite_rst_flags", {busy_o, done_o, error_o, write_count_o}, 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1; sccb_ready_i = 1;
    repeat (3) @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
